// File: rtl/modmul_pkg.sv
// Shared constants for the 94-bit modular datapath (P = 2^94 - 3) and the
// modexp_seq state encoding.
package modmul_pkg;
  localparam int WIDTH = 94;
  localparam logic [WIDTH-1:0] MODULUS = {{(WIDTH-2){1'b1}}, 2'b01};

  typedef enum logic [1:0] {S_IDLE, S_SQR, S_MUL, S_DONE} modexp_state_e;
endpackage

// File: rtl/modexp_seq_if.sv
// Request/result bundle between a requester and modexp_seq.
interface modexp_seq_if #(
  parameter int W  = modmul_pkg::WIDTH,
  parameter int EW = 94
);
  logic          start;
  logic [W-1:0]  a;
  logic [EW-1:0] e;
  logic          busy;
  logic          done;
  logic [W-1:0]  r;

  modport master (output start, a, e, input  busy, done, r);
  modport slave  (input  start, a, e, output busy, done, r);
endinterface

// File: rtl/modmul.sv
// Combinational z = x*y mod P for P = 2^W - c with small c; operands may be
// any W-bit value, the result is always fully reduced.
module modmul
  import modmul_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);
  // 2^W mod P; for P = 2^94-3 this is 3, so two folds bring the product below 2P
  localparam logic [WIDTH-1:0] FOLD_W = ~MODULUS + WIDTH'(1);
  localparam logic [1:0]       FOLD   = FOLD_W[1:0];

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH+1:0]   t1;
  logic [WIDTH:0]     t2;
  logic               unused_clk_rst;

  assign unused_clk_rst = clk ^ reset;

  always_comb begin
    prod = (2*WIDTH)'(x) * (2*WIDTH)'(y);
    t1   = (WIDTH+2)'(prod[WIDTH-1:0])
         + (WIDTH+2)'(prod[2*WIDTH-1:WIDTH]) * (WIDTH+2)'(FOLD);
    t2   = (WIDTH+1)'(t1[WIDTH-1:0])
         + (WIDTH+1)'(t1[WIDTH+1:WIDTH]) * (WIDTH+1)'(FOLD);
    z    = (t2 >= {1'b0, MODULUS}) ? WIDTH'(t2 - {1'b0, MODULUS}) : t2[WIDTH-1:0];
  end
endmodule

// File: rtl/modexp_seq.sv
// Left-to-right square-and-multiply r = a^e mod P on one shared modmul.
// Optional MODEXP_SEQ_EARLY_EXIT_EN starts the scan at the top set bit of e.
module modexp_seq
  import modmul_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int EW = 94
) (
  input  logic         clk,
  input  logic         reset,
  modexp_seq_if.slave  bus
);
  localparam int IW = (EW > 1) ? $clog2(EW) : 1;

  modexp_state_e state_q, state_d;
  logic [W-1:0]  acc_q, acc_d, base_q, base_d, r_q, r_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  mm_b, mm_y;

  assign mm_b = (state_q == S_MUL) ? base_q : acc_q;

  modmul u_modmul (
    .clk   (clk),
    .reset (reset),
    .x     (acc_q),
    .y     (mm_b),
    .z     (mm_y)
  );

`ifdef MODEXP_SEQ_EARLY_EXIT_EN
  function automatic logic [IW-1:0] msb_idx(input logic [EW-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < EW; i++) if (v[i]) msb_idx = IW'(i);
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    exp_d   = exp_q;
    idx_d   = idx_q;
    r_d     = r_q;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        base_d  = bus.a;
        exp_d   = bus.e;
        acc_d   = W'(1);
        state_d = S_SQR;
`ifdef MODEXP_SEQ_EARLY_EXIT_EN
        idx_d = msb_idx(bus.e);
        if (bus.e == '0) begin
          state_d = S_DONE;
          r_d     = W'(1);
        end
`else
        idx_d = IW'(EW-1);
`endif
      end
      S_SQR, S_MUL: begin
        acc_d = mm_y;
        if (state_q == S_SQR && exp_q[idx_q]) state_d = S_MUL;
        else if (idx_q == '0) begin
          // r is published on entry to DONE so it is valid in the done cycle
          state_d = S_DONE;
          r_d     = mm_y;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = S_SQR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      idx_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      idx_q   <= idx_d;
      r_q     <= r_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.r    = r_q;
endmodule

// File: tb/tb_modexp_seq.sv
// Self-checking bench for modexp_seq: timing-level reference model compared
// every cycle, plus directed cases and randomized operands.
`timescale 1ns/1ps
module tb_modexp_seq;
  import modmul_pkg::*;

  localparam int W  = WIDTH;
  localparam int EW = 94;
  localparam logic [2*W-1:0] P2  = {{W{1'b0}}, MODULUS};
  localparam logic [W-1:0]   PM1 = 94'h3FFF_FFFF_FFFF_FFFF_FFFF_FFFC;
`ifdef MODEXP_SEQ_EARLY_EXIT_EN
  localparam int LAT_2_10 = 6;
  localparam int STALL    = 2;
`else
  localparam int LAT_2_10 = 96;
  localparam int STALL    = 8;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  modexp_seq_if #(.W(W), .EW(EW)) bus();
  modexp_seq #(.W(W), .EW(EW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  logic         m_busy = 1'b0, m_done = 1'b0;
  logic [W-1:0] m_r = '0, m_pend = '0;
  int           left = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Right-to-left binary powering with plain wide arithmetic.
  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [EW-1:0] x);
    logic [2*W-1:0] res, bb;
    res = 1;
    bb  = {{W{1'b0}}, b} % P2;
    for (int i = 0; i < EW; i++) begin
      if (x[i]) res = (res * bb) % P2;
      bb = (bb * bb) % P2;
    end
    return res[W-1:0];
  endfunction

  function automatic int lat(input logic [EW-1:0] x);
`ifdef MODEXP_SEQ_EARLY_EXIT_EN
    int m;
    m = -1;
    for (int i = 0; i < EW; i++) if (x[i]) m = i;
    return (x == '0) ? 0 : m + 1 + $countones(x);
`else
    return EW + $countones(x);
`endif
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  function automatic logic [EW-1:0] rnd_e();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       return t[EW-1:0];
      1:       return EW'(t[7:0]);
      2:       return '0;
      default: return '1;
    endcase
  endfunction

  // Reference: a started job finishes exactly lat(e) edges after acceptance.
  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_r = '0; left = 0;
    end else if (m_done) begin
      m_done = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      left--;
      if (left == 0) begin m_done = 1'b1; m_r = m_pend; end
    end else if (bus.start) begin
      m_busy = 1'b1;
      m_pend = ref_pow(bus.a, bus.e);
      left   = lat(bus.e);
      if (left == 0) begin m_done = 1'b1; m_r = m_pend; end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", W'(bus.busy), W'(m_busy));
      chk("done", W'(bus.done), W'(m_done));
      chk("r", bus.r, m_r);
      if (bus.done) done_cnt++;
    end
  end

  task automatic do_start(input logic [W-1:0] av, input logic [EW-1:0] ev);
    @(negedge clk);
    bus.a = av; bus.e = ev; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.a = rnd_w(); bus.e = rnd_e();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      checks++; errors++;
      $display("FAIL timeout: no done within %0d cycles", n);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dc;
    logic [W-1:0]  av;
    logic [EW-1:0] ev;
    bus.start = 1'b0; bus.a = '0; bus.e = '0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_r", bus.r, '0);
    reset = 1'b0;

    chk("ref_2_10", ref_pow(W'(2), EW'(10)), W'(1024));
    chk("ref_pm1_2", ref_pow(PM1, EW'(2)), W'(1));
    chk("ref_pm1_3", ref_pow(PM1, EW'(3)), PM1);
    chk("ref_3_7", ref_pow(W'(3), EW'(7)), W'(2187));
    chk("ref_0_0", ref_pow('0, '0), W'(1));

    do_start(W'(2), EW'(10));
    wait_done(n);
    chk("lat_2_10", W'(n), W'(LAT_2_10));
    chk("r_2_10", bus.r, W'(1024));

    do_start(PM1, EW'(2)); wait_done(n); chk("r_pm1_2", bus.r, W'(1));
    do_start(PM1, EW'(3)); wait_done(n); chk("r_pm1_3", bus.r, PM1);

    do_start('0, '0); wait_done(n); chk("r_0_0", bus.r, W'(1));
    @(negedge clk); chk("done_width_0_0", W'(bus.done), '0);
    do_start('0, EW'(5)); wait_done(n); chk("r_0_5", bus.r, '0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_width_0_5", W'(bus.done), '0);
    chk("start_in_done_ignored", W'(bus.busy), '0);

    dc = done_cnt;
    do_start(W'(3), EW'(7));
    repeat (STALL) @(negedge clk);
    bus.a = W'(5); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    chk("r_3_7", bus.r, W'(2187));
    repeat (2) @(negedge clk);
    chk("single_done", W'(done_cnt - dc), W'(1));

    do_start(W'(2), EW'(10));
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", W'(bus.busy), '0);
    chk("midrst_done", W'(bus.done), '0);
    chk("midrst_r", bus.r, '0);
    dc = done_cnt;
    repeat (120) @(negedge clk);
    chk("midrst_no_done", W'(done_cnt - dc), '0);
    do_start(W'(2), EW'(10)); wait_done(n); chk("r_after_rst", bus.r, W'(1024));

    for (int k = 0; k < 300; k++) begin
      av = rnd_w();
      case ($urandom_range(0, 7))
        0: av = '0;
        1: av = PM1;
        2: av = MODULUS;
        3: av = '1;
        default: ;
      endcase
      ev = rnd_e();
      do_start(av, ev);
      if (lat(ev) >= 3 && $urandom_range(0, 3) == 0) begin
        bus.start = 1'b1; bus.a = rnd_w();
        @(negedge clk);
        bus.start = 1'b0;
      end
      wait_done(n);
      chk("rand_r", bus.r, ref_pow(av, ev));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
